// File: rtl/regfile_pkg.sv
// Shared defaults and the index decoder used by the register file for both the
// write-enable vector and the scoreboard reserve vector.
package regfile_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_NREGS    = 8;
  localparam int RF_IDX_W    = 6;
  localparam int RF_MAX_REGS = 2 ** RF_IDX_W;

  // Bits at or above the instantiating file's NREGS are simply dropped by the caller,
  // which is what makes out-of-range indices a no-op.
  function automatic logic [RF_MAX_REGS-1:0] rf_onehot(input logic [RF_IDX_W-1:0] idx,
                                                       input logic                en);
    logic [RF_MAX_REGS-1:0] v;
    v      = '0;
    v[idx] = en;
    return v;
  endfunction

endpackage

// File: rtl/rf_reg_rst.sv
// One register-file entry: DATA_W flop with synchronous active-high clear and load enable.
module rf_reg_rst #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] val_q;

  always_ff @(posedge clk) begin
    if (reset)       val_q <= '0;
    else if (load_i) val_q <= d_i;
  end

  assign q_o = val_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write register file with optional write->read forwarding, optional registered
// read, and a per-register busy scoreboard (reserve at issue, clear at writeback).
module regfile_2r1w_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int NREGS    = RF_NREGS,
  parameter  int BYPASS   = 1,
  parameter  int READ_REG = 0,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [AW-1:0]     writenum,
  input  logic              write,
  input  logic [AW-1:0]     readnum_a,
  input  logic [AW-1:0]     readnum_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              reserve,
  input  logic [AW-1:0]     reservenum,
  output logic              busy_a,
  output logic              busy_b,
  output logic [NREGS-1:0]  busy_mask
);

  localparam int            NP      = 2;
  localparam logic [AW:0]   NREGS_C = (AW+1)'(NREGS);

  logic [RF_MAX_REGS-1:0]         we_full, rsv_full;
  logic [NREGS-1:0]               we_vec, rsv_vec;
  logic [NREGS-1:0]               busy_q, busy_d;
  logic [NREGS-1:0][DATA_W-1:0]   rf_q;
  logic [NP-1:0][AW-1:0]          rnum;
  logic [NP-1:0][DATA_W-1:0]      sel, dout;
  logic [NP-1:0]                  busy_rd;

  assign we_full  = rf_onehot(RF_IDX_W'(writenum), write);
  assign rsv_full = rf_onehot(RF_IDX_W'(reservenum), reserve);
  assign we_vec   = we_full[NREGS-1:0];
  assign rsv_vec  = rsv_full[NREGS-1:0];

  if (NREGS < RF_MAX_REGS) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^{we_full[RF_MAX_REGS-1:NREGS], rsv_full[RF_MAX_REGS-1:NREGS]};
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    rf_reg_rst #(.DATA_W(DATA_W)) u_reg (
      .clk    (clk),
      .reset  (reset),
      .load_i (we_vec[i]),
      .d_i    (data_in),
      .q_o    (rf_q[i])
    );
  end

  // Clear-then-set ordering: a reserve on the register being written back wins.
  assign busy_d = (busy_q & ~we_vec) | rsv_vec;

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign rnum = {readnum_b, readnum_a};

  for (genvar p = 0; p < NP; p++) begin : g_rd
    logic in_rng, fwd_hit, rsv_hit;

    assign in_rng  = {1'b0, rnum[p]} < NREGS_C;
    assign fwd_hit = (BYPASS != 0) && write && (writenum == rnum[p]) && in_rng;
    assign rsv_hit = reserve && (reservenum == rnum[p]);

    assign sel[p] = !in_rng ? '0 :
                    fwd_hit ? data_in : rf_q[rnum[p]];

    // A forwarded value is not a hazard, unless a new producer claims the same slot.
    assign busy_rd[p] = !in_rng             ? 1'b0 :
                        (fwd_hit && !rsv_hit) ? 1'b0 : busy_q[rnum[p]];

    if (READ_REG != 0) begin : g_rq
      logic [DATA_W-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (reset) rd_q <= '0;
        else       rd_q <= sel[p];
      end
      assign dout[p] = rd_q;
    end else begin : g_rc
      assign dout[p] = sel[p];
    end
  end

  assign data_out_a = dout[0];
  assign data_out_b = dout[1];
  assign busy_a     = busy_rd[0];
  assign busy_b     = busy_rd[1];
  assign busy_mask  = busy_q;

endmodule
